// File: rtl/prefetch_pkg.sv
// Shared defaults and FIFO entry layout for the instruction prefetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a. PREFETCH_PC_EN adds the pc field to each entry.
package prefetch_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_ROM_LATENCY = 1;
  localparam int DEF_RESET_PC    = 0;

  typedef struct packed {
`ifdef PREFETCH_PC_EN
    logic [DEF_ADDR_WIDTH-1:0] pc;
`endif
    logic [DEF_WIDTH-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding returned instruction words; flush beats push and pop.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: pop on empty is ignored; the caller's credit rule prevents push on full.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = DEF_DEPTH,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch: runs a fetch PC ahead of the consumer, tracks ROM reads in flight, queues returns.
// Latency: reset/redirect to first instr_valid is ROM_LATENCY+1 / ROM_LATENCY+2 cycles.
// Backpressure: issue stalls once queued + in-flight reaches DEPTH; PREFETCH_PC_EN adds instr_pc.
module instruction_prefetch
  import prefetch_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ROM_LATENCY = DEF_ROM_LATENCY,
  parameter int RESET_PC    = DEF_RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [WIDTH-1:0]      rom_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_address,
  output logic                  instr_valid,
  output logic [WIDTH-1:0]      instr_data,
`ifdef PREFETCH_PC_EN
  output logic [ADDR_WIDTH-1:0] instr_pc,
`endif
  input  logic                  instr_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
`ifdef PREFETCH_PC_EN
    logic [ADDR_WIDTH-1:0] pc;
`endif
    logic [WIDTH-1:0]      instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ROM_LATENCY-1:0] trk_vld;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_empty;
  entry_t                 fifo_head;
  entry_t                 push_data;
  logic                   issue;
  int                     inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      if (trk_vld[i]) inflight = inflight + 1;
    end
  end

  // Credit: every issued read already owns a FIFO slot, so the push can never overflow.
  assign issue = !redirect && ((int'(fifo_count) + inflight) < DEPTH);

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= ADDR_WIDTH'(RESET_PC);
      trk_vld  <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_address;
      trk_vld  <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
      for (int i = ROM_LATENCY - 1; i > 0; i--) trk_vld[i] <= trk_vld[i-1];
      trk_vld[0] <= issue;
    end
  end

`ifdef PREFETCH_PC_EN
  logic [ADDR_WIDTH-1:0] trk_pc [ROM_LATENCY];

  // PC tags ride alongside the valid bits; stale tags are harmless since valid gates the push.
  always_ff @(posedge clock) begin
    for (int i = ROM_LATENCY - 1; i > 0; i--) trk_pc[i] <= trk_pc[i-1];
    trk_pc[0] <= fetch_pc;
  end

  assign push_data.pc = trk_pc[ROM_LATENCY-1];
  assign instr_pc     = fifo_empty ? '0 : fifo_head.pc;
`endif

  assign push_data.instr = rom_data;

  prefetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (trk_vld[ROM_LATENCY-1]),
    .push_data (push_data),
    .pop       (instr_ready),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rom_address = fetch_pc;
  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_empty ? '0 : fifo_head.instr;

endmodule
